// File: rtl/i2c_slave_if.sv
// rtl/i2c_slave_if.sv - I2C target bus pins and local byte-stream signals
interface i2c_slave_if;
  logic       sda;
  logic       sda_out;
  logic       scl;
  logic       scl_out;
  logic [7:0] rx_dat;
  logic       rx_vld;
  logic       rx_nack;
  logic       rx_rdy;
  logic [7:0] tx_dat;
  logic       tx_req;
  logic       tx_vld;
  logic       sel;
  logic       rw;
  logic       sto;

  modport slave (
    input  sda, scl, rx_nack, rx_rdy, tx_dat, tx_vld,
    output sda_out, scl_out, rx_dat, rx_vld, tx_req, sel, rw, sto
  );

  modport master (
    output sda, scl, rx_nack, rx_rdy, tx_dat, tx_vld,
    input  sda_out, scl_out, rx_dat, rx_vld, tx_req, sel, rw, sto
  );
endinterface

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target controller; clock stretching enabled by I2C_SLAVE_STRETCH_EN
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h50,
  parameter int         FLT  = 3,
  parameter int         HOLD = 2
) (
  input logic        clk,
  input logic        rst,
  i2c_slave_if.slave bus
);
  localparam int FW = (FLT > 1) ? $clog2(FLT) : 1;
  localparam int HW = $clog2(HOLD + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AACK, S_RX, S_RACK, S_TX, S_TACK, S_IGNR} state_t;

  state_t           state_q, state_d;
  logic [1:0]       s1_q, s1_d, s2_q, s2_d, f_q, f_d, p_q, p_d;
  logic [1:0][FW-1:0] fc_q, fc_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       sh_q, sh_d, rx_dat_q, rx_dat_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic ph_q, ph_d, sda_out_q, sda_out_d, pend_q, pend_d;
  logic rx_vld_q, rx_vld_d, tx_req_q, tx_req_d, sel_q, sel_d;
  logic rw_q, rw_d, sto_q, sto_d, nack_q, nack_d, str_q, str_d;
  logic sda_f, scl_f, start, stop, scl_rise, scl_fall;
  logic launch, launch_val, fin9, go_tx, chk, rdy;
  logic [7:0] shift_in;

  // Bit 0 carries SDA, bit 1 carries SCL through synchronizer and glitch filter
  always_comb begin
    s1_d = {bus.scl, bus.sda};
    s2_d = s1_q;
    p_d  = f_q;
    f_d  = f_q;
    fc_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != f_q[i]) begin
        if (fc_q[i] == FW'(FLT - 1)) f_d[i] = s2_q[i];
        else                          fc_d[i] = fc_q[i] + FW'(1);
      end
    end
  end

  assign sda_f    = f_q[0];
  assign scl_f    = f_q[1];
  assign start    = scl_f & p_q[1] & p_q[0] & ~sda_f;
  assign stop     = scl_f & p_q[1] & ~p_q[0] & sda_f;
  assign scl_rise = scl_f & ~p_q[1];
  assign scl_fall = ~scl_f & p_q[1];
  assign shift_in = {sh_q[6:0], sda_f};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    ph_d      = ph_q;
    sda_out_d = sda_out_q;
    pend_d    = pend_q;
    hold_d    = hold_q;
    rx_dat_d  = rx_dat_q;
    rx_vld_d  = 1'b0;
    tx_req_d  = 1'b0;
    sel_d     = sel_q;
    rw_d      = rw_q;
    sto_d     = 1'b0;
    nack_d    = rx_vld_q ? bus.rx_nack : nack_q;
    str_d     = str_q;
    launch    = 1'b0;
    launch_val = 1'b1;
    fin9      = 1'b0;
    go_tx     = 1'b0;
    chk       = 1'b0;
    case (state_q)
      S_ADDR: if (scl_rise) begin
        sh_d = shift_in;
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else if (shift_in[7:1] == ADDR && shift_in[7:1] != 7'h00) begin
          state_d = S_AACK;
          rw_d    = shift_in[0];
          ph_d    = 1'b0;
        end else state_d = S_IGNR;
      end
      S_AACK: if (!ph_q) begin
        if (scl_fall) begin
          ph_d = 1'b1; sel_d = 1'b1; launch = 1'b1; launch_val = 1'b0;
        end
      end else begin
        if (scl_rise && rw_q) tx_req_d = 1'b1;
        if (scl_fall) begin fin9 = 1'b1; go_tx = rw_q; chk = rw_q; end
      end
      S_RX: if (str_q) begin
        fin9 = 1'b1; chk = 1'b1;
      end else if (scl_rise) begin
        sh_d = shift_in;
        if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;
        else begin
          rx_dat_d = shift_in; rx_vld_d = 1'b1; state_d = S_RACK; ph_d = 1'b0;
        end
      end
      S_RACK: if (scl_fall) begin
        if (!ph_q) begin ph_d = 1'b1; launch = 1'b1; launch_val = nack_q; end
        else begin fin9 = 1'b1; chk = 1'b1; end
      end
      S_TX: if (str_q) begin
        fin9 = 1'b1; go_tx = 1'b1; chk = 1'b1;
      end else if (scl_fall) begin
        launch = 1'b1;
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1; sh_d = {sh_q[6:0], 1'b0}; launch_val = sh_q[6];
        end else begin
          state_d = S_TACK; ph_d = 1'b0;
        end
      end
      S_TACK: if (scl_rise) begin
        if (!sda_f) begin ph_d = 1'b1; tx_req_d = 1'b1; end
        else begin state_d = S_IGNR; sel_d = 1'b0; end
      end else if (ph_q && scl_fall) begin
        fin9 = 1'b1; go_tx = 1'b1; chk = 1'b1;
      end
      default: ;
    endcase

`ifdef I2C_SLAVE_STRETCH_EN
    rdy = !chk || (go_tx ? bus.tx_vld : bus.rx_rdy);
`else
    rdy = 1'b1;
`endif
    // End of an ACK slot: either start the next byte now or hold SCL low until the local side is ready
    if (fin9) begin
      cnt_d   = 3'd7;
      state_d = go_tx ? S_TX : S_RX;
      ph_d    = 1'b0;
      if (rdy) begin
        str_d = 1'b0; launch = 1'b1;
        launch_val = go_tx ? bus.tx_dat[7] : 1'b1;
        if (go_tx) sh_d = bus.tx_dat;
      end else str_d = 1'b1;
    end

    if (launch) begin
      pend_d = launch_val;
      hold_d = HW'(HOLD);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
      if (hold_q == HW'(1)) sda_out_d = pend_q;
    end

    if (state_q == S_IDLE || state_q == S_IGNR) begin
      sda_out_d = 1'b1; hold_d = '0;
    end
    if (start || stop) begin
      state_d   = start ? S_ADDR : S_IDLE;
      cnt_d     = 3'd7;
      ph_d      = 1'b0;
      sel_d     = 1'b0;
      sto_d     = stop;
      sda_out_d = 1'b1;
      hold_d    = '0;
      str_d     = 1'b0;
      rx_vld_d  = 1'b0;
      rx_dat_d  = rx_dat_q;
      tx_req_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;  s1_q <= 2'b11; s2_q <= 2'b11; f_q <= 2'b11; p_q <= 2'b11;
      fc_q <= '0; cnt_q <= 3'd7; sh_q <= '0; rx_dat_q <= '0; hold_q <= '0;
      ph_q <= 1'b0; sda_out_q <= 1'b1; pend_q <= 1'b1; rx_vld_q <= 1'b0; tx_req_q <= 1'b0;
      sel_q <= 1'b0; rw_q <= 1'b0; sto_q <= 1'b0; nack_q <= 1'b0; str_q <= 1'b0;
    end else begin
      state_q <= state_d; s1_q <= s1_d; s2_q <= s2_d; f_q <= f_d; p_q <= p_d;
      fc_q <= fc_d; cnt_q <= cnt_d; sh_q <= sh_d; rx_dat_q <= rx_dat_d; hold_q <= hold_d;
      ph_q <= ph_d; sda_out_q <= sda_out_d; pend_q <= pend_d; rx_vld_q <= rx_vld_d; tx_req_q <= tx_req_d;
      sel_q <= sel_d; rw_q <= rw_d; sto_q <= sto_d; nack_q <= nack_d; str_q <= str_d;
    end
  end

`ifndef I2C_SLAVE_STRETCH_EN
  logic unused_in;
  assign unused_in = bus.rx_rdy ^ bus.tx_vld;
`endif

  assign bus.sda_out = sda_out_q;
  assign bus.scl_out = ~str_q;
  assign bus.rx_dat  = rx_dat_q;
  assign bus.rx_vld  = rx_vld_q;
  assign bus.tx_req  = tx_req_q;
  assign bus.sel     = sel_q;
  assign bus.rw      = rw_q;
  assign bus.sto     = sto_q;
endmodule
